// File: rtl/cart_pkg.sv
// ---------------------------------------------------------------------------
// cart_pkg
// Shared definitions for the MBC1 cartridge model: the a[15:13] region codes
// that select which bank register a bus write targets, and the read-source
// select carried from the request cycle into the data-return cycle.
// No ports (package only).
// ---------------------------------------------------------------------------
package cart_pkg;

   // Write-decode regions, taken from a[15:13]
   localparam logic [2:0] REG_RAMEN  = 3'b000;
   localparam logic [2:0] REG_BANKLO = 3'b001;
   localparam logic [2:0] REG_BANKHI = 3'b010;
   localparam logic [2:0] REG_MODE   = 3'b011;
   localparam logic [2:0] REG_XRAM   = 3'b101;

   // Where the data for a launched read comes from one cycle later
   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_ROM,
      SEL_RAM,
      SEL_FF
   } rdSel_e;

endpackage

// File: rtl/cart_sram.sv
// ---------------------------------------------------------------------------
// cart_sram
// Single-port synchronous byte RAM standing in for the battery-backed
// cartridge SRAM. Write-first: a write returns the new byte on rdata_o.
// Contents are never reset.
// Ports:
//   clk_i    clock
//   we_i     write enable for this cycle
//   addr_i   byte address (ADDR_W bits)
//   wdata_i  write data
//   rdata_o  registered read data for the address seen on the last edge
// ---------------------------------------------------------------------------
module cart_sram #(
   parameter int ADDR_W = 15
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem [0:(1<<ADDR_W)-1];

   // Storage array plus read register; on a write the fresh byte is forwarded
   // so a read of the same location in the next cycle never sees stale data.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
         rdata_o     <= wdata_i;
      end else begin
         rdata_o     <= mem[addr_i];
      end
   end

endmodule

// File: rtl/cart_mbc1.sv
// ---------------------------------------------------------------------------
// cart_mbc1
// MBC1 cartridge bus responder. Bus writes to 0000-7FFF program the bank
// registers, writes to A000-BFFF go to the internal SRAM, and reads are
// mapped onto an external synchronous ROM or the SRAM with data returned
// one clock after the request.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   a, din, dout    bus address, write data, read data
//   wr, rd, cs      write enable, read enable, cycle strobe
//   rom_a, rom_d    registered address to / data from the external ROM
//   ram_en_o        current RAM-enable register
// ---------------------------------------------------------------------------
module cart_mbc1
   import cart_pkg::*;
#(
   parameter int ROM_ADDR_W  = 21,
   parameter int RAM_ADDR_W  = 15,
   parameter bit RAM_PRESENT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           a,
   input  logic [7:0]            din,
   output logic [7:0]            dout,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  cs,
   output logic [ROM_ADDR_W-1:0] rom_a,
   input  logic [7:0]            rom_d,
   output logic                  ram_en_o
);

   localparam logic [6:0] ROM_BANK_MASK = 7'((1 << (ROM_ADDR_W - 14)) - 1);
   localparam logic [1:0] RAM_BANK_MASK = 2'((1 << (RAM_ADDR_W - 13)) - 1);

   logic                  ramEn_q;
   logic [4:0]            bankLo_q;
   logic [1:0]            bankHi_q;
   logic                  mode_q;
   logic                  wr_q;
   logic [ROM_ADDR_W-1:0] romA_q, romA_d;
   rdSel_e                rdSel_q, rdSel_d;
   logic [7:0]            doutHold_q;

   logic [2:0]  region;
   logic        wrStb;
   logic        rdAcc;
   logic        sramWe;
   logic [4:0]  loEff;
   logic [6:0]  romBank;
   logic [20:0] romAFull;
   logic [1:0]  ramBank;
   logic [14:0] ramAFull;
   logic [7:0]  ramQ;

   assign region   = a[15:13];
   assign wrStb    = cs & wr & ~wr_q;
   assign rdAcc    = cs & rd & ~wr;
   assign sramWe   = RAM_PRESENT & wrStb & ~rst & ramEn_q & (region == REG_XRAM);
   assign rom_a    = romA_q;
   assign ram_en_o = ramEn_q;

   // Bank arithmetic and read launch. A zero low bank becomes one on the full
   // five bits, so 0x20/0x40/0x60 still land on 0x21/0x41/0x61. The ROM
   // address only moves on a ROM read, keeping the external ROM quiet
   // otherwise.
   always_comb begin
      loEff    = (bankLo_q == 5'd0) ? 5'd1 : bankLo_q;
      romBank  = a[14] ? {bankHi_q, loEff} : (mode_q ? {bankHi_q, 5'b0} : 7'd0);
      romAFull = {romBank & ROM_BANK_MASK, a[13:0]};
      ramBank  = (mode_q ? bankHi_q : 2'b00) & RAM_BANK_MASK;
      ramAFull = {ramBank, a[12:0]};
      romA_d   = romA_q;
      rdSel_d  = SEL_NONE;
      if (rdAcc) begin
         if (!a[15]) begin
            rdSel_d = SEL_ROM;
            romA_d  = romAFull[ROM_ADDR_W-1:0];
         end else if (RAM_PRESENT && ramEn_q && (region == REG_XRAM)) begin
            rdSel_d = SEL_RAM;
         end else begin
            rdSel_d = SEL_FF;
         end
      end
   end

   // Data return: in the cycle after a launched read the chosen source drives
   // dout; otherwise the last returned byte is replayed from the hold register.
   always_comb begin
      case (rdSel_q)
         SEL_ROM: dout = rom_d;
         SEL_RAM: dout = ramQ;
         SEL_FF:  dout = 8'hFF;
         default: dout = doutHold_q;
      endcase
   end

   // Bank registers, write-edge detector and read pipeline state. wr_q comes
   // out of reset high so a write held across reset release is not taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         ramEn_q    <= 1'b0;
         bankLo_q   <= 5'd0;
         bankHi_q   <= 2'd0;
         mode_q     <= 1'b0;
         wr_q       <= 1'b1;
         romA_q     <= '0;
         rdSel_q    <= SEL_NONE;
         doutHold_q <= 8'hFF;
      end else begin
         wr_q       <= cs & wr;
         romA_q     <= romA_d;
         rdSel_q    <= rdSel_d;
         doutHold_q <= dout;
         if (wrStb) begin
            case (region)
               REG_RAMEN:  ramEn_q  <= (din[3:0] == 4'hA);
               REG_BANKLO: bankLo_q <= din[4:0];
               REG_BANKHI: bankHi_q <= din[1:0];
               REG_MODE:   mode_q   <= din[0];
               default: ;
            endcase
         end
      end
   end

   // Internal SRAM only exists when the cartridge has one; otherwise the
   // RAM window floats high.
   if (RAM_PRESENT) begin : g_sram
      cart_sram #(
         .ADDR_W(RAM_ADDR_W)
      ) u_sram (
         .clk_i  (clk),
         .we_i   (sramWe),
         .addr_i (ramAFull[RAM_ADDR_W-1:0]),
         .wdata_i(din),
         .rdata_o(ramQ)
      );
   end else begin : g_nosram
      assign ramQ = 8'hFF;
   end

endmodule

// File: tb/tb_cart_mbc1.sv
// ---------------------------------------------------------------------------
// tb_cart_mbc1
// Directed bench for cart_mbc1: bank mapping, mode select, SRAM gating,
// single-update write pulses, read/write collision and reset behaviour.
// The external ROM returns a fixed function of its address.
// ---------------------------------------------------------------------------
module tb_cart_mbc1;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        wr;
   logic        rd;
   logic        cs;
   logic [20:0] rom_a;
   logic [7:0]  rom_d;
   logic        ram_en_o;

   int errors;
   int checks;

   cart_mbc1 #(
      .ROM_ADDR_W (21),
      .RAM_ADDR_W (15),
      .RAM_PRESENT(1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .din     (din),
      .dout    (dout),
      .wr      (wr),
      .rd      (rd),
      .cs      (cs),
      .rom_a   (rom_a),
      .rom_d   (rom_d),
      .ram_en_o(ram_en_o)
   );

   // ROM content model: each byte is a fold of its own address
   function automatic logic [7:0] romF(input logic [20:0] x);
      return x[7:0] ^ x[15:8] ^ {3'b000, x[20:16]};
   endfunction

   assign rom_d = romF(rom_a);

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bus transaction started on a falling edge. A write is followed by an
   // idle cycle (from the next call) so each call is a fresh pulse; a read
   // returns in the data cycle, #1 after inputs drop, ready for checking.
   task automatic applyStimulus(input logic doWrite, input logic [15:0] addr,
                                input logic [7:0] data);
      @(negedge clk);
      cs  = 1'b1;
      a   = addr;
      din = data;
      wr  = doWrite;
      rd  = ~doWrite;
      @(negedge clk);
      cs = 1'b0;
      wr = 1'b0;
      rd = 1'b0;
      #1;
   endtask

   // Reset values of the visible state
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (dout !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL reset_dout: got %h expected ff", dout);
      end
      checks++;
      if (rom_a !== 21'h0) begin
         errors++;
         $display("[TB] FAIL reset_rom_a: got %h expected 000000", rom_a);
      end
      checks++;
      if (ram_en_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ram_en: got %b expected 0", ram_en_o);
      end
   endtask

   // Plain ROM reads from both windows with default banks
   task automatic test_rom_basic();
      applyStimulus(1'b0, 16'h0150, 8'h00);
      checks++;
      if (rom_a !== 21'h00150) begin
         errors++;
         $display("[TB] FAIL rom0150_addr: got %h expected 000150", rom_a);
      end
      checks++;
      if (dout !== 8'h51) begin
         errors++;
         $display("[TB] FAIL rom0150_data: got %h expected 51", dout);
      end
      applyStimulus(1'b0, 16'h4000, 8'h00);
      checks++;
      if (rom_a !== 21'h04000) begin
         errors++;
         $display("[TB] FAIL rom4000_addr: got %h expected 004000", rom_a);
      end
      checks++;
      if (dout !== 8'h40) begin
         errors++;
         $display("[TB] FAIL rom4000_data: got %h expected 40", dout);
      end
   endtask

   // Zero low bank maps to one, including with the high bits set
   task automatic test_bank_zero();
      applyStimulus(1'b1, 16'h2000, 8'h00);
      applyStimulus(1'b0, 16'h4123, 8'h00);
      checks++;
      if (rom_a !== 21'h04123 || dout !== 8'h62) begin
         errors++;
         $display("[TB] FAIL bank0_as_1: got %h/%h expected 004123/62", rom_a, dout);
      end
      applyStimulus(1'b1, 16'h2000, 8'h20);
      applyStimulus(1'b1, 16'h4000, 8'h01);
      applyStimulus(1'b0, 16'h4000, 8'h00);
      checks++;
      if (rom_a !== 21'h84000 || dout !== 8'h48) begin
         errors++;
         $display("[TB] FAIL bank21: got %h/%h expected 084000/48", rom_a, dout);
      end
      applyStimulus(1'b1, 16'h2000, 8'h05);
      applyStimulus(1'b0, 16'h7FFF, 8'h00);
      checks++;
      if (rom_a !== 21'h97FFF) begin
         errors++;
         $display("[TB] FAIL bank25_top: got %h expected 097fff", rom_a);
      end
   endtask

   // Mode 1 applies the high bank bits to the 0000-3FFF window
   task automatic test_mode();
      applyStimulus(1'b1, 16'h4000, 8'h02);
      applyStimulus(1'b1, 16'h6000, 8'h01);
      applyStimulus(1'b0, 16'h0001, 8'h00);
      checks++;
      if (rom_a !== 21'h100001 || dout !== 8'h11) begin
         errors++;
         $display("[TB] FAIL mode1_low: got %h/%h expected 100001/11", rom_a, dout);
      end
      applyStimulus(1'b1, 16'h6000, 8'h00);
      applyStimulus(1'b0, 16'h0001, 8'h00);
      checks++;
      if (rom_a !== 21'h000001) begin
         errors++;
         $display("[TB] FAIL mode0_low: got %h expected 000001", rom_a);
      end
   endtask

   // A read in the cycle right after a bank write uses the new bank
   task automatic test_back_to_back();
      @(negedge clk);
      cs  = 1'b1;
      wr  = 1'b1;
      rd  = 1'b0;
      a   = 16'h2000;
      din = 8'h03;
      @(negedge clk);
      wr = 1'b0;
      rd = 1'b1;
      a  = 16'h4000;
      @(negedge clk);
      cs = 1'b0;
      rd = 1'b0;
      #1;
      checks++;
      if (rom_a !== 21'h10C000) begin
         errors++;
         $display("[TB] FAIL back_to_back: got %h expected 10c000", rom_a);
      end
   endtask

   // SRAM enable gating and bank separation under mode 1
   task automatic test_sram();
      applyStimulus(1'b0, 16'hA000, 8'h00);
      checks++;
      if (dout !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL ram_disabled: got %h expected ff", dout);
      end
      applyStimulus(1'b1, 16'h0000, 8'h0A);
      checks++;
      if (ram_en_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ram_enable: got %b expected 1", ram_en_o);
      end
      applyStimulus(1'b1, 16'hA000, 8'h5A);
      applyStimulus(1'b0, 16'hA000, 8'h00);
      checks++;
      if (dout !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL ram_rw: got %h expected 5a", dout);
      end
      applyStimulus(1'b1, 16'h6000, 8'h01);
      applyStimulus(1'b1, 16'hA000, 8'h77);
      applyStimulus(1'b0, 16'hA000, 8'h00);
      checks++;
      if (dout !== 8'h77) begin
         errors++;
         $display("[TB] FAIL ram_bank2: got %h expected 77", dout);
      end
      applyStimulus(1'b1, 16'h6000, 8'h00);
      applyStimulus(1'b0, 16'hA000, 8'h00);
      checks++;
      if (dout !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL ram_bank0_kept: got %h expected 5a", dout);
      end
      applyStimulus(1'b1, 16'h0000, 8'h00);
      applyStimulus(1'b0, 16'hA000, 8'h00);
      checks++;
      if (ram_en_o !== 1'b0 || dout !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL ram_disable_again: got %b/%h expected 0/ff", ram_en_o, dout);
      end
   endtask

   // A long write pulse stores only the data present on its first cycle
   task automatic test_write_hold();
      applyStimulus(1'b1, 16'h0000, 8'h0A);
      @(negedge clk);
      cs  = 1'b1;
      wr  = 1'b1;
      a   = 16'hA001;
      din = 8'h11;
      @(negedge clk);
      din = 8'h22;
      repeat (7) @(negedge clk);
      cs = 1'b0;
      wr = 1'b0;
      applyStimulus(1'b0, 16'hA001, 8'h00);
      checks++;
      if (dout !== 8'h11) begin
         errors++;
         $display("[TB] FAIL write_hold: got %h expected 11", dout);
      end
   endtask

   // rd and wr together count as a write; dout keeps the previous byte
   task automatic test_rd_wr_together();
      @(negedge clk);
      cs  = 1'b1;
      rd  = 1'b1;
      wr  = 1'b1;
      a   = 16'h8000;
      din = 8'h00;
      @(negedge clk);
      cs = 1'b0;
      rd = 1'b0;
      wr = 1'b0;
      #1;
      checks++;
      if (dout !== 8'h11) begin
         errors++;
         $display("[TB] FAIL rd_wr_together: got %h expected 11", dout);
      end
   endtask

   // Reset landing on a read request discards it and restores default banks
   task automatic test_reset_mid_read();
      applyStimulus(1'b1, 16'h4000, 8'h01);
      applyStimulus(1'b1, 16'h2000, 8'h07);
      applyStimulus(1'b1, 16'h6000, 8'h01);
      @(negedge clk);
      cs  = 1'b1;
      rd  = 1'b1;
      a   = 16'h4000;
      rst = 1'b1;
      @(negedge clk);
      cs  = 1'b0;
      rd  = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (dout !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL rst_mid_read_dout: got %h expected ff", dout);
      end
      checks++;
      if (rom_a !== 21'h0 || ram_en_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_mid_read_regs: got %h/%b expected 000000/0", rom_a, ram_en_o);
      end
      applyStimulus(1'b0, 16'h4000, 8'h00);
      checks++;
      if (rom_a !== 21'h04000) begin
         errors++;
         $display("[TB] FAIL rst_banks_default: got %h expected 004000", rom_a);
      end
      applyStimulus(1'b0, 16'h0001, 8'h00);
      checks++;
      if (rom_a !== 21'h000001) begin
         errors++;
         $display("[TB] FAIL rst_mode_default: got %h expected 000001", rom_a);
      end
   endtask

   // A write held across reset release is ignored; SRAM survives reset
   task automatic test_wr_through_reset();
      @(negedge clk);
      rst = 1'b1;
      cs  = 1'b1;
      wr  = 1'b1;
      rd  = 1'b0;
      a   = 16'h0000;
      din = 8'h0A;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      cs = 1'b0;
      wr = 1'b0;
      #1;
      checks++;
      if (ram_en_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_through_reset: got %b expected 0", ram_en_o);
      end
      applyStimulus(1'b1, 16'h0000, 8'h0A);
      checks++;
      if (ram_en_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fresh_write_after_reset: got %b expected 1", ram_en_o);
      end
      applyStimulus(1'b0, 16'hA000, 8'h00);
      checks++;
      if (dout !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL sram_kept_over_reset: got %h expected 5a", dout);
      end
   endtask

   // Test sequence
   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      cs     = 1'b0;
      wr     = 1'b0;
      rd     = 1'b0;
      a      = 16'h0000;
      din    = 8'h00;
      test_reset();
      test_rom_basic();
      test_bank_zero();
      test_mode();
      test_back_to_back();
      test_sram();
      test_write_hold();
      test_rd_wr_together();
      test_reset_mid_read();
      test_wr_through_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
